// File: rtl/mem_access_unit.sv
// Load/store unit between the core datapath and a word-addressed synchronous data memory.
// Sub-word stores use read-modify-write; bad accesses complete with fault and never reach memory.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           load_data,
    output logic                  done,
    output logic                  fault,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    store_q;
    logic [2:0]              funct3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             wdata_q;
    logic [31:0]             load_data_q;
    logic                    done_q;
    logic                    fault_q;
    logic                    busy_q;
    logic [31:0]             mem_wdata_q;
    logic                    mem_we_q;

    logic                    supported_d;
    logic                    misaligned_d;
    logic                    bad_d;
    logic [7:0]              byte_d;
    logic [15:0]             half_d;
    logic [31:0]             load_ext_d;
    logic [31:0]             merged_d;
    logic [3:0]              lane_sel_d;

    // Classification looks at the live inputs because it is only used on the accepting edge.
    always_comb begin
        supported_d  = 1'b0;
        misaligned_d = 1'b0;
        if (is_store) begin
            supported_d = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            supported_d = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)
                       || (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        if (funct3[1:0] == 2'b01) begin
            misaligned_d = addr[0];
        end else if (funct3[1:0] == 2'b10) begin
            misaligned_d = (addr[1:0] != 2'b00);
        end
        bad_d = !supported_d || misaligned_d;
    end

    always_comb begin
        byte_d     = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_d     = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext_d = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext_d = {{24{byte_d[7]}}, byte_d};
            3'b001:  load_ext_d = {{16{half_d[15]}}, half_d};
            3'b100:  load_ext_d = {24'd0, byte_d};
            3'b101:  load_ext_d = {16'd0, half_d};
            default: load_ext_d = mem_rdata;
        endcase
    end

    // Store merge: each byte lane takes store data if selected, else keeps the memory byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_sel_d[gi] = (funct3_q[1:0] == 2'b00) ? (addr_q[1:0] == LANE)
                                                             : (addr_q[1] == LANE[1]);
            assign merged_d[8*gi +: 8] = !lane_sel_d[gi]          ? mem_rdata[8*gi +: 8] :
                                         (funct3_q[1:0] == 2'b00) ? wdata_q[7:0]
                                                                  : wdata_q[8*(gi%2) +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 16'd0;
            load_data_q <= 32'd0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_wdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        store_q  <= is_store;
                        funct3_q <= funct3;
                        addr_q   <= addr;
                        wdata_q  <= wdata[15:0];
                        busy_q   <= 1'b1;
                        fault_q  <= bad_d;
                        if (bad_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (is_store && (funct3 == 3'b010)) begin
                            state_q     <= WRITE;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= wdata;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (store_q) begin
                        state_q     <= WRITE;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged_d;
                    end else begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        load_data_q <= load_ext_d;
                    end
                end
                WRITE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign load_data = load_data_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign busy      = busy_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random accesses against a byte-level
// reference model of the memory and of the load/store semantics.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] mem [0:255];

    logic [31:0] ref_mem [0:255];
    logic [31:0] ref_load;
    logic [31:0] last_load;
    logic [31:0] last_we_data;
    int          total;
    int          errs;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .load_data (load_data),
        .done      (done),
        .fault     (fault),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory, read-before-write, with a preload port for the bench.
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic unsup;
        logic mis;
        unsup = st ? (f3 > 3'd2) : !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        mis   = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        return unsup || mis;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'h100 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'h10000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] val;
        if (f3 == 3'd0) begin
            mask = 32'hFF << (8 * a[1:0]);
            val  = (wd & 32'hFF) << (8 * a[1:0]);
        end else begin
            mask = 32'hFFFF << (16 * a[1]);
            val  = (wd & 32'hFFFF) << (16 * a[1]);
        end
        return (w & ~mask) | (val & mask);
    endfunction

    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
        logic        bad;
        int          exp_done;
        int          exp_we;
        int          idx;
        logic [31:0] exp_word;
        logic [31:0] exp_load;
        int          done_cyc;
        int          we_cyc;
        int          we_cnt;
        logic [31:0] we_addr;
        logic        got_fault;
        idx      = int'(a[9:2]);
        bad      = model_bad(st, f3, a);
        exp_word = ref_mem[idx];
        exp_load = ref_load;
        if (bad) begin
            exp_done = 1; exp_we = 0;
        end else if (st && f3 == 3'd2) begin
            exp_done = 2; exp_we = 1; exp_word = wd;
        end else if (st) begin
            exp_done = 4; exp_we = 3; exp_word = model_merge(ref_mem[idx], f3, a, wd);
        end else begin
            exp_done = 3; exp_we = 0; exp_load = model_load(ref_mem[idx], f3, a);
        end

        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        done_cyc = 0; we_cyc = 0; we_cnt = 0; we_addr = 0; got_fault = 1'b0;
        last_we_data = 32'd0;
        for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
            @(negedge clk);
            start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
            addr = $urandom; wdata = $urandom;
            if (c == 1) chk("busy_c1", {31'd0, busy}, 32'd1);
            if (mem_we) begin
                we_cnt++; we_cyc = c; we_addr = mem_addr; last_we_data = mem_wdata;
            end
            if (done) begin
                done_cyc = c; last_load = load_data; got_fault = fault;
            end
        end
        chk("done_cycle", done_cyc, exp_done);
        chk("we_count", we_cnt, (exp_we != 0) ? 1 : 0);
        if (exp_we != 0) begin
            chk("we_cycle", we_cyc, exp_we);
            chk("we_addr", we_addr, {a[31:2], 2'b00});
            chk("we_data", last_we_data, exp_word);
        end
        chk("load_data", last_load, exp_load);
        chk("fault", {31'd0, got_fault}, {31'd0, bad});
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("fault_held", {31'd0, fault}, {31'd0, bad});
        if (st && !bad) begin
            ref_mem[idx] = exp_word;
            chk("mem_word", mem[idx], exp_word);
        end
        ref_load = exp_load;
        $display("txn st=%0d f3=%0d addr=%h wdata=%h done@%0d we=%0d load=%h fault=%0d",
                 st, f3, a, wd, done_cyc, we_cnt, last_load, got_fault);
    endtask

    initial begin
        int done_cnt;
        int done_c1;
        int done_c2;
        int we_seen;
        total = 0; errs = 0;
        reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        pre_we = 1'b0; pre_idx = 8'd0; pre_data = 32'd0;
        ref_load = 32'd0; last_load = 32'd0; last_we_data = 32'd0;

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_idx = 8'(i);
            pre_data = (i == 'h40) ? 32'h8899AABB : $urandom;
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;

        run_access(1'b0, 3'd0, 32'h103, 32'd0); chk("lb_const",  last_load, 32'hFFFFFF88);
        run_access(1'b0, 3'd4, 32'h101, 32'd0); chk("lbu_const", last_load, 32'h000000AA);
        run_access(1'b0, 3'd1, 32'h102, 32'd0); chk("lh_const",  last_load, 32'hFFFF8899);
        run_access(1'b0, 3'd5, 32'h100, 32'd0); chk("lhu_const", last_load, 32'h0000AABB);
        run_access(1'b0, 3'd2, 32'h100, 32'd0); chk("lw_const",  last_load, 32'h8899AABB);
        run_access(1'b1, 3'd0, 32'h101, 32'h12345677); chk("sb_const", last_we_data, 32'h889977BB);
        run_access(1'b1, 3'd2, 32'h100, 32'h8899AABB);
        run_access(1'b1, 3'd1, 32'h102, 32'h0000CAFE); chk("sh_const", last_we_data, 32'hCAFEAABB);
        run_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF); chk("sw_const", last_we_data, 32'hDEADBEEF);
        run_access(1'b0, 3'd2, 32'h100, 32'd0); chk("lw_after_sw", last_load, 32'hDEADBEEF);
        run_access(1'b0, 3'd2, 32'h102, 32'd0); chk("bad_lw_keep", last_load, 32'hDEADBEEF);
        run_access(1'b1, 3'd1, 32'h101, 32'h5555);
        run_access(1'b0, 3'd3, 32'h100, 32'd0); chk("bad_f3_keep", last_load, 32'hDEADBEEF);
        run_access(1'b0, 3'd4, 32'h100, 32'd0); chk("fault_clear_load", last_load, 32'h000000EF);

        // Reset during CAPTURE of an SB must suppress the write entirely.
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'd0; addr = 32'h101; wdata = 32'h000000AB;
        we_seen = 0;
        @(negedge clk); start = 1'b0; we_seen += int'(mem_we);
        @(negedge clk); reset = 1'b1; we_seen += int'(mem_we);
        @(negedge clk);
        reset = 1'b0; we_seen += int'(mem_we);
        chk("mid_rst_load_data", load_data, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); we_seen += int'(mem_we);
        end
        chk("mid_rst_no_we", we_seen, 0);
        chk("mid_rst_mem", mem['h40], ref_mem['h40]);
        ref_load = 32'd0;

        // start held across an LH: accepted again only once the unit is back in IDLE.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'd1; addr = 32'h102; wdata = 32'd0;
        done_cnt = 0; done_c1 = 0; done_c2 = 0; we_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 5) start = 1'b0;
            we_seen += int'(mem_we);
            if (done) begin
                done_cnt++;
                if (done_c1 == 0) done_c1 = c; else done_c2 = c;
            end
        end
        ref_load = model_load(ref_mem['h40], 3'd1, 32'h102);
        chk("held_done_count", done_cnt, 2);
        chk("held_done_first", done_c1, 3);
        chk("held_done_second", done_c2, 7);
        chk("held_no_we", we_seen, 0);
        chk("held_load", load_data, ref_load);
        $display("txn held-start LH addr=00000102 dones=%0d at %0d,%0d load=%h",
                 done_cnt, done_c1, done_c2, load_data);

        for (int n = 0; n < 150; n++) begin
            run_access(1'($urandom), 3'($urandom), 32'h100 + $urandom_range(0, 63), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, errs);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side load/store unit for the multicycle RISC-V core. It sits between the datapath and a word-addressed synchronous data memory.
- Loads: reads the containing word, then extracts the byte/halfword lane with sign- or zero-extension.
- Stores: SW writes directly. SB/SH use a read-modify-write to merge the byte lanes.
- Detects misaligned and unsupported accesses and never touches memory for them.

Parameters:
ADDR_WIDTH, 32, width of byte address and mem_addr.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
is_store  input  1  1 = store, 0 = load; sampled with start
funct3  input  3  RISC-V width/sign code; sampled with start
addr  input  ADDR_WIDTH  byte address; sampled with start
wdata  input  32  store data, low bits used for SB/SH; sampled with start
load_data  output  32  extended load result; valid from done, held until next load completes
done  output  1  one-cycle completion pulse
fault  output  1  set with done for misaligned/unsupported access; held until next start
busy  output  1  high whenever state != IDLE
mem_addr  output  ADDR_WIDTH  word address {addr_q[ADDR_WIDTH-1:2],2'b00}
mem_wdata  output  32  word written to memory
mem_we  output  1  memory write enable, one cycle per store
mem_rdata  input  32  memory read data, valid the cycle after mem_addr is presented with mem_we=0

Behaviour:
- Reset values: load_data=0, done=0, fault=0, busy=0, mem_addr=0, mem_wdata=0, mem_we=0; state=IDLE.
- Reset wins over everything. Reset mid-operation aborts the access, so no mem_we follows. The next cycle is IDLE.
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- IDLE, start=1: latch is_store, funct3, addr, wdata. Classify:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is unsupported.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Bad (unsupported or misaligned) access: IDLE→DONE with fault=1. No read or write is issued. load_data is unchanged.
- SW: IDLE→WRITE→DONE. mem_wdata=wdata_q.
- Load, SB, SH: IDLE→READ→CAPTURE.
  - Load then goes CAPTURE→DONE.
  - SB/SH then go CAPTURE→WRITE→DONE.
- READ: mem_addr presented, mem_we=0.
- CAPTURE: mem_rdata is sampled.
  - Load: load_data is registered at the CAPTURE→DONE edge.
  - Store: the merged word is registered into mem_wdata.
- Lanes are little-endian. Byte k = bits [8k+7:8k], k=addr[1:0]. Halfword at addr[1]=0 → [15:0], addr[1]=1 → [31:16].
- Extension:
  - LB/LH: sign-extend lane MSB.
  - LBU/LHU: zero-extend.
  - LW: word unchanged.
- Merge: SB replaces byte k with wdata_q[7:0]. SH replaces the selected halfword with wdata_q[15:0]. All other lanes come from mem_rdata.
- WRITE: mem_we=1 for exactly this cycle. mem_addr and mem_wdata are stable during it.
- DONE: done=1 for one cycle, then →IDLE. The unit accepts a new start on the cycle after DONE.
- start while busy is ignored; it is not queued.
- Latency, counting from the start-sampling edge as cycle 0:
  - bad access: done in cycle 1
  - SW: mem_we in cycle 1, done in cycle 2
  - load: done in cycle 3
  - SB/SH: mem_we in cycle 3, done in cycle 4
- fault clears on the next accepted start.
- mem_we=0 in every state except WRITE.

Test Plan:
- Memory word 0x100 = 0x8899AABB. Loads issued: LB 0x103, LBU 0x101, LH 0x102, LHU 0x100, LW 0x100 → load_data 0xFFFFFF88, 0x000000AA, 0xFFFF8899, 0x0000AABB, 0x8899AABB. done in cycle 3; mem_we never high.
- SB addr 0x101, wdata 0x12345677, word 0x8899AABB → single mem_we in cycle 3 with mem_addr 0x100, mem_wdata 0x889977BB. done in cycle 4.
- SH addr 0x102, wdata 0x0000CAFE → mem_wdata 0xCAFEAABB. Then SW addr 0x100, wdata 0xDEADBEEF → mem_we in cycle 1 with no READ state visited, done in cycle 2. A following LW returns 0xDEADBEEF.
- LW 0x102, SH 0x101, and load funct3=011 → fault=1 and done in cycle 1, mem_we never asserted, load_data keeps its previous value. The next valid start clears fault.
- SB started, then reset asserted during CAPTURE → no mem_we ever. The next cycle is IDLE with all outputs 0. The memory word is unchanged.
- start held high throughout an LH → exactly one access and one done per accepted start. Back-to-back starts are accepted only in IDLE.
